mux_32x1: RTL and testbench
===========================

// Module: mux_32x1
//
// PURPOSE
//  32-to-1 single-bit multiplexer with a registered output.
//  A 5-bit select, given as scalar pins s0..s4, picks one of 32 scalar data inputs d0..d31.
//  Built hierarchically as four 8:1 muxes feeding a 4:1 mux.
//  Used as a leaf selector wherever a wide one-hot or bit-addressed source must collapse to one bit.
//
// PARAMETERS
//  REGISTER_OUT  1  1: out is registered (1-cycle latency); 0: out is the pure combinational mux (clk/rst unused)
//
// PORTS
//  clk      in   1  clock, rising-edge active
//  rst      in   1  reset, synchronous, active-high
//  d0..d31  in   1  data inputs (32 separate scalar ports, in this order)
//  s0       in   1  select bit 4 (MSB)
//  s1       in   1  select bit 3
//  s2       in   1  select bit 2
//  s3       in   1  select bit 1
//  s4       in   1  select bit 0 (LSB)
//  out      out  1  selected data bit
//  - Port order for positional instantiation: d0..d31, s0, s1, s2, s3, s4, out, clk, rst.
//
// BEHAVIOUR
//  - Select index sel = {s0,s1,s2,s3,s4}, an unsigned value from 0 to 31. The selected bit is d[sel].
//    Examples: s0=1, others 0 -> d16; s4=1, others 0 -> d1; all ones -> d31.
//  - Combinational stage: sel[4:3] = {s0,s1} picks one of four groups. sel[2:0] = {s2,s3,s4} picks the bit within the group.
//    Groups: g0 = d0..d7, g1 = d8..d15, g2 = d16..d23, g3 = d24..d31.
//  - REGISTER_OUT=1:
//      - On each rising clk edge: if rst, out <= 0; else out <= d[sel] as sampled at that edge.
//      - Latency is exactly one clock. out holds its value between edges.
//      - Changes to data or select between edges have no effect on out until the next edge.
//      - rst asserted mid-stream clears out at the next edge, regardless of inputs.
//      - The first edge after rst deasserts loads the current selection. There is no extra bubble.
//  - REGISTER_OUT=0:
//      - out = d[sel] combinationally, with zero latency.
//      - No reset effect.
//  - Reset value of out: 0 (registered variant).
//  - Every one of the 32 select codes is legal. There are no unused codes and no error output.
//  - Unselected inputs never influence out. A toggling unselected d must leave out unchanged.
//  - X or Z on select: no defined requirement beyond standard synthesis semantics.
//  - No latches. All combinational logic is fully specified (default branches present).
//
// STRUCTURE
//  - Sub-module mux_8x1 (d[7:0] scalar, 3 selects, y), instantiated 4 times, one per group.
//  - Final 4:1 stage on {s0,s1}, either inline or as sub-module mux_4x1.
//  - Output register plus generate-if on REGISTER_OUT in the top level.
//  - Shared package: constants N_IN=32, SEL_W=5, GRP_W=8. No typedefs needed.
//
// TESTING (REGISTER_OUT=1 unless noted; check out one cycle after driving inputs)
//  1. Reset: rst=1 for 2 cycles with d0=1, sel=0 -> out=0. Release rst -> out=1 on the next edge.
//  2. Walking one: for k = 0..31, set sel=k, d_k=1, all other d=0 -> out=1 each cycle.
//     Repeat with the inverted pattern (d_k=0, others 1) -> out=0.
//  3. Isolation: sel=16 ({s0..s4}=10000), d16=0, toggle every other d each cycle -> out stays 0.
//  4. Latency: sel=31, d31 goes 0->1 just after edge N -> out=0 at edge N, out=1 at edge N+1.
//  5. Mid-operation reset: sel=5, d5=1, out=1. Pulse rst for one cycle -> out=0 that edge, then out=1.
//  6. REGISTER_OUT=0: step through sel 0..31 every 5 ns with a walking one -> out=1 within the same delta, no clock needed.

Source files
------------

// File: rtl/mux_32x1_pkg.sv
// ============================================================================
// Module      : mux_32x1_pkg
// Description : Shared sizing constants for the 32:1 bit selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_32x1_pkg;

    localparam int N_IN  = 32;
    localparam int SEL_W = 5;
    localparam int GRP_W = 8;
    localparam int N_GRP = N_IN / GRP_W;

endpackage : mux_32x1_pkg

`default_nettype wire

// File: rtl/mux_32x1_8x1.sv
// ============================================================================
// Module      : mux_8x1
// Description : Combinational 8:1 single-bit multiplexer, one per input group.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8x1
    import mux_32x1_pkg::*;
(
    input  logic [GRP_W-1:0] d_i,
    input  logic [2:0]       sel_i,
    output logic             y_o
);

    always_comb begin
        y_o = 1'b0;
        case (sel_i)
            3'd0:    y_o = d_i[0];
            3'd1:    y_o = d_i[1];
            3'd2:    y_o = d_i[2];
            3'd3:    y_o = d_i[3];
            3'd4:    y_o = d_i[4];
            3'd5:    y_o = d_i[5];
            3'd6:    y_o = d_i[6];
            3'd7:    y_o = d_i[7];
            default: y_o = 1'b0;
        endcase
    end

endmodule : mux_8x1

`default_nettype wire

// File: rtl/mux_32x1.sv
// ============================================================================
// Module      : mux_32x1
// Description : 32:1 single-bit mux (four 8:1 groups + 4:1 stage), optional
//               registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_32x1
    import mux_32x1_pkg::*;
#(
    parameter bit REGISTER_OUT = 1'b1
)(
    input  logic d0,  input logic d1,  input logic d2,  input logic d3,
    input  logic d4,  input logic d5,  input logic d6,  input logic d7,
    input  logic d8,  input logic d9,  input logic d10, input logic d11,
    input  logic d12, input logic d13, input logic d14, input logic d15,
    input  logic d16, input logic d17, input logic d18, input logic d19,
    input  logic d20, input logic d21, input logic d22, input logic d23,
    input  logic d24, input logic d25, input logic d26, input logic d27,
    input  logic d28, input logic d29, input logic d30, input logic d31,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    input  logic s3,
    input  logic s4,
    output logic out,
    input  logic clk,
    input  logic rst
);

    logic [N_IN-1:0]  w_d;
    logic [SEL_W-1:0] w_sel;
    logic [N_GRP-1:0] w_grp_y;
    logic             w_out_d;

    assign w_d = {d31, d30, d29, d28, d27, d26, d25, d24,
                  d23, d22, d21, d20, d19, d18, d17, d16,
                  d15, d14, d13, d12, d11, d10, d9,  d8,
                  d7,  d6,  d5,  d4,  d3,  d2,  d1,  d0};

    // s0 is the MSB of the index, s4 the LSB.
    assign w_sel = {s0, s1, s2, s3, s4};

    generate
        for (genvar g = 0; g < N_GRP; g++) begin : g_grp
            mux_8x1 u_mux_8x1 (
                .d_i   (w_d[g*GRP_W +: GRP_W]),
                .sel_i (w_sel[2:0]),
                .y_o   (w_grp_y[g])
            );
        end
    endgenerate

    always_comb begin
        w_out_d = 1'b0;
        case (w_sel[4:3])
            2'd0:    w_out_d = w_grp_y[0];
            2'd1:    w_out_d = w_grp_y[1];
            2'd2:    w_out_d = w_grp_y[2];
            2'd3:    w_out_d = w_grp_y[3];
            default: w_out_d = 1'b0;
        endcase
    end

    generate
        if (REGISTER_OUT) begin : g_reg
            logic r_out_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_q <= 1'b0;
                end else begin
                    r_out_q <= w_out_d;
                end
            end

            assign out = r_out_q;
        end else begin : g_comb
            // Clock and reset have no role in the purely combinational variant.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign out = w_out_d;
        end
    endgenerate

endmodule : mux_32x1

`default_nettype wire

// File: tb/tb_mux_32x1.sv
// ============================================================================
// Module      : tb_mux_32x1
// Description : Self-checking bench for registered and combinational mux_32x1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_32x1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dv  = '0;
    logic [4:0]  sel = '0;
    logic        out_reg;
    logic        out_comb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_32x1 #(.REGISTER_OUT(1'b1)) u_dut_reg (
        .d0(dv[0]),   .d1(dv[1]),   .d2(dv[2]),   .d3(dv[3]),
        .d4(dv[4]),   .d5(dv[5]),   .d6(dv[6]),   .d7(dv[7]),
        .d8(dv[8]),   .d9(dv[9]),   .d10(dv[10]), .d11(dv[11]),
        .d12(dv[12]), .d13(dv[13]), .d14(dv[14]), .d15(dv[15]),
        .d16(dv[16]), .d17(dv[17]), .d18(dv[18]), .d19(dv[19]),
        .d20(dv[20]), .d21(dv[21]), .d22(dv[22]), .d23(dv[23]),
        .d24(dv[24]), .d25(dv[25]), .d26(dv[26]), .d27(dv[27]),
        .d28(dv[28]), .d29(dv[29]), .d30(dv[30]), .d31(dv[31]),
        .s0(sel[4]), .s1(sel[3]), .s2(sel[2]), .s3(sel[1]), .s4(sel[0]),
        .out(out_reg), .clk(clk), .rst(rst)
    );

    mux_32x1 #(.REGISTER_OUT(1'b0)) u_dut_comb (
        .d0(dv[0]),   .d1(dv[1]),   .d2(dv[2]),   .d3(dv[3]),
        .d4(dv[4]),   .d5(dv[5]),   .d6(dv[6]),   .d7(dv[7]),
        .d8(dv[8]),   .d9(dv[9]),   .d10(dv[10]), .d11(dv[11]),
        .d12(dv[12]), .d13(dv[13]), .d14(dv[14]), .d15(dv[15]),
        .d16(dv[16]), .d17(dv[17]), .d18(dv[18]), .d19(dv[19]),
        .d20(dv[20]), .d21(dv[21]), .d22(dv[22]), .d23(dv[23]),
        .d24(dv[24]), .d25(dv[25]), .d26(dv[26]), .d27(dv[27]),
        .d28(dv[28]), .d29(dv[29]), .d30(dv[30]), .d31(dv[31]),
        .s0(sel[4]), .s1(sel[3]), .s2(sel[2]), .s3(sel[1]), .s4(sel[0]),
        .out(out_comb), .clk(clk), .rst(rst)
    );

    // Reference: the index is the plain unsigned number {s0..s4}.
    function automatic logic model_pick(input logic [31:0] d, input logic [4:0] s);
        int idx;
        idx = int'(s);
        return d[idx];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected registered value is what the model picks from the inputs held
    // across the coming edge; sampled 1 ns after that edge.
    task automatic step(input string tag);
        logic e;
        e = rst ? 1'b0 : model_pick(dv, sel);
        @(posedge clk);
        #1;
        chk(tag, out_reg, e);
    endtask

    initial begin
        // Reset holds out low even with the selected input high.
        rst = 1'b1; dv = 32'h1; sel = 5'd0;
        step("reset_c1");
        step("reset_c2");
        chk("reset_fixed0", out_reg, 1'b0);
        rst = 1'b0;
        step("reset_release");
        chk("reset_release_is1", out_reg, 1'b1);

        // Walking one, then walking zero.
        for (int k = 0; k < 32; k++) begin
            sel = 5'(k);
            dv  = 32'h1 << k;
            #1 chk("walk1_comb", out_comb, 1'b1);
            step("walk1_reg");
        end
        for (int k = 0; k < 32; k++) begin
            sel = 5'(k);
            dv  = ~(32'h1 << k);
            #1 chk("walk0_comb", out_comb, 1'b0);
            step("walk0_reg");
        end

        // Isolation: only unselected inputs toggle.
        sel = 5'd16;
        dv  = 32'h0;
        for (int k = 0; k < 8; k++) begin
            dv = dv ^ ~(32'h1 << 16);
            #1 chk("iso_comb", out_comb, 1'b0);
            step("iso_reg");
        end

        // One-cycle latency: change between edges is invisible until next edge.
        sel = 5'd31; dv = 32'h0;
        step("lat_edgeN");
        dv[31] = 1'b1;
        #2 chk("lat_hold", out_reg, 1'b0);
        chk("lat_comb", out_comb, 1'b1);
        step("lat_edgeN1");

        // Mid-stream reset pulse.
        sel = 5'd5; dv = 32'h20;
        step("mid_pre");
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        step("mid_post");

        // Combinational variant: walking one every 5 ns.
        for (int k = 0; k < 32; k++) begin
            sel = 5'(k);
            dv  = 32'h1 << k;
            #1 chk("comb_walk", out_comb, 1'b1);
            #4;
        end
        @(posedge clk); #1;

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 200; k++) begin
            dv  = $urandom;
            sel = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 15) == 0);
            #1 chk("rand_comb", out_comb, model_pick(dv, sel));
            step("rand_reg");
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_32x1

`default_nettype wire
